fp_mult_pipe: RTL and testbench

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

---
 rtl/fp_mult_pipe_pkg.sv | 35 +++
 rtl/fp_mult_pipe_round_exc.sv | 96 +++++++++
 rtl/fp_mult_pipe.sv | 166 ++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pipe_pkg.sv
// Shared definitions for the pipelined floating-point multiplier: rounding
// modes, status bit positions and constructors for special encodings.
package fp_mult_pipe_pkg;

  typedef enum logic [2:0] {
    RND_NEAR    = 3'd0,
    RND_ZERO    = 3'd1,
    RND_PINF    = 3'd2,
    RND_NINF    = 3'd3,
    RND_NEAR_UP = 3'd4,
    RND_AWAY    = 3'd5
  } round_mode_e;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_NAN     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  // Encodings are built in a 64-bit container; callers truncate to their word width.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_max_finite(input logic s, input int exp_w, input int man_w);
    return (64'(s) << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd2) << man_w) |
           ((64'd1 << man_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_min_norm(input logic s, input int exp_w, input int man_w);
    return (64'(s) << (exp_w + man_w)) | (64'd1 << man_w);
  endfunction

endpackage

// File: rtl/fp_mult_pipe_round_exc.sv
// Final-stage combinational rounding and exception resolution for the multiplier.
module fp_round_exc
  import fp_mult_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                      sign,
  input  logic                      nan,
  input  logic                      inf,
  input  logic                      zero,
  input  logic signed [EXP_W+1:0]   exp,
  input  logic [MAN_W-1:0]          man,
  input  logic                      guard,
  input  logic                      sticky,
  input  logic [2:0]                rnd,
  output logic [EXP_W+MAN_W:0]      z,
  output logic [7:0]                status
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 2);
  localparam logic signed [EW-1:0] EXP_MIN  = EW'(1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [W-1:0]         QNAN     = W'(fp_qnan(EXP_W, MAN_W));

  function automatic logic round_inc(input logic [2:0] mode, input logic s, input logic lsb,
                                     input logic g, input logic st);
    case (mode)
      RND_ZERO:    return 1'b0;
      RND_PINF:    return !s && (g || st);
      RND_NINF:    return s && (g || st);
      RND_NEAR_UP: return g && (st || !s);
      RND_AWAY:    return g || st;
      default:     return g && (st || lsb);
    endcase
  endfunction

  // Overflow saturates to the largest finite value only when the mode rounds toward zero.
  function automatic logic ovf_to_inf(input logic [2:0] mode, input logic s);
    case (mode)
      RND_ZERO: return 1'b0;
      RND_PINF: return !s;
      RND_NINF: return s;
      default:  return 1'b1;
    endcase
  endfunction

  logic                 inc;
  logic                 to_inf;
  logic [MAN_W:0]       man_r;
  logic signed [EW-1:0] exp_r;

  always_comb begin
    inc    = round_inc(rnd, sign, man[0], guard, sticky);
    man_r  = {1'b0, man} + {{MAN_W{1'b0}}, inc};
    exp_r  = exp + $signed({{(EW-1){1'b0}}, man_r[MAN_W]});
    to_inf = ovf_to_inf(rnd, sign);
  end

  always_comb begin
    z      = '0;
    status = '0;
    if (nan) begin
      z               = QNAN;
      status[ST_NAN]  = 1'b1;
    end else if (inf) begin
      z               = {sign, EXP_ONES, {MAN_W{1'b0}}};
      status[ST_INF]  = 1'b1;
    end else if (zero) begin
      z               = {sign, {(W-1){1'b0}}};
      status[ST_ZERO] = 1'b1;
    end else if (exp < EXP_MIN) begin
      status[ST_TINY]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
      case (rnd)
        RND_AWAY: z = W'(fp_min_norm(sign, EXP_W, MAN_W));
        RND_PINF: z = sign ? {1'b1, {(W-1){1'b0}}} : W'(fp_min_norm(1'b0, EXP_W, MAN_W));
        RND_NINF: z = sign ? W'(fp_min_norm(1'b1, EXP_W, MAN_W)) : '0;
        default:  z = {sign, {(W-1){1'b0}}};
      endcase
      status[ST_ZERO] = (z[W-2:0] == '0);
    end else if (exp_r > EXP_MAX) begin
      status[ST_HUGE]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
      status[ST_INF]     = to_inf;
      z = to_inf ? {sign, EXP_ONES, {MAN_W{1'b0}}} : W'(fp_max_finite(sign, EXP_W, MAN_W));
    end else begin
      // A mantissa carry-out leaves man_r low bits at zero and bumps exp_r.
      z                  = {sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
      status[ST_INEXACT] = guard | sticky;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier with a single global advance/stall signal.
module fp_mult_pipe
  import fp_mult_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [2:0]           round,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] z,
  output logic [7:0]           status
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * (MAN_W + 1);
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic [EXP_W-1:0]     a_exp, b_exp;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                 cls_nan, cls_inf, cls_zero;
  logic [MAN_W:0]       man_a, man_b;
  logic [PW-1:0]        prod;
  logic signed [EW-1:0] exp_a_s, exp_b_s, exp_sum;

  // Exponent field zero covers both true zero and denormals, which are flushed.
  always_comb begin
    a_exp    = a[W-2:MAN_W];
    b_exp    = b[W-2:MAN_W];
    a_zero   = (a_exp == '0);
    b_zero   = (b_exp == '0);
    a_inf    = (&a_exp) && !(|a[MAN_W-1:0]);
    b_inf    = (&b_exp) && !(|b[MAN_W-1:0]);
    a_nan    = (&a_exp) && (|a[MAN_W-1:0]);
    b_nan    = (&b_exp) && (|b[MAN_W-1:0]);
    cls_nan  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
    cls_inf  = !cls_nan && (a_inf || b_inf);
    cls_zero = !cls_nan && !cls_inf && (a_zero || b_zero);
    man_a    = {1'b1, a[MAN_W-1:0]};
    man_b    = {1'b1, b[MAN_W-1:0]};
    prod     = PW'(man_a) * PW'(man_b);
    exp_a_s  = {2'b00, a_exp};
    exp_b_s  = {2'b00, b_exp};
    exp_sum  = exp_a_s + exp_b_s - BIAS;
  end

  // ---- S1: unpack / classify / multiply ----
  logic                 vld_p0, sign_p0, nan_p0, inf_p0, zero_p0;
  logic signed [EW-1:0] exp_p0;
  logic [PW-1:0]        prod_p0;
  logic [2:0]           rnd_p0;

  always_ff @(posedge clk) begin
    if (rst)          vld_p0 <= 1'b0;
    else if (advance) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      sign_p0 <= a[W-1] ^ b[W-1];
      nan_p0  <= cls_nan;
      inf_p0  <= cls_inf;
      zero_p0 <= cls_zero;
      exp_p0  <= exp_sum;
      prod_p0 <= prod;
      rnd_p0  <= round;
    end
  end

  logic                 shift_n;
  logic signed [EW-1:0] exp_n;
  logic [MAN_W-1:0]     frac_n;
  logic                 guard_n, sticky_n;

  // Product lies in [1,4); a set MSB means one extra bit of integer part.
  always_comb begin
    shift_n = prod_p0[PW-1];
    if (shift_n) begin
      exp_n    = exp_p0 + EXP_ONE;
      frac_n   = prod_p0[PW-2 -: MAN_W];
      guard_n  = prod_p0[MAN_W];
      sticky_n = |prod_p0[MAN_W-1:0];
    end else begin
      exp_n    = exp_p0;
      frac_n   = prod_p0[PW-3 -: MAN_W];
      guard_n  = prod_p0[MAN_W-1];
      sticky_n = |prod_p0[MAN_W-2:0];
    end
  end

  // ---- S2: normalise, guard/sticky ----
  logic                 vld_p1, sign_p1, nan_p1, inf_p1, zero_p1, guard_p1, sticky_p1;
  logic signed [EW-1:0] exp_p1;
  logic [MAN_W-1:0]     frac_p1;
  logic [2:0]           rnd_p1;

  always_ff @(posedge clk) begin
    if (rst)          vld_p1 <= 1'b0;
    else if (advance) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      sign_p1   <= sign_p0;
      nan_p1    <= nan_p0;
      inf_p1    <= inf_p0;
      zero_p1   <= zero_p0;
      exp_p1    <= exp_n;
      frac_p1   <= frac_n;
      guard_p1  <= guard_n;
      sticky_p1 <= sticky_n;
      rnd_p1    <= rnd_p0;
    end
  end

  logic [W-1:0] z_s3;
  logic [7:0]   status_s3;

  fp_round_exc #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_exc (
    .sign   (sign_p1),
    .nan    (nan_p1),
    .inf    (inf_p1),
    .zero   (zero_p1),
    .exp    (exp_p1),
    .man    (frac_p1),
    .guard  (guard_p1),
    .sticky (sticky_p1),
    .rnd    (rnd_p1),
    .z      (z_s3),
    .status (status_s3)
  );

  // ---- S3: round / exceptions / output register ----
  logic         vld_p2;
  logic [W-1:0] z_p2;
  logic [7:0]   status_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      z_p2      <= '0;
      status_p2 <= '0;
    end else if (advance) begin
      vld_p2    <= vld_p1;
      z_p2      <= z_s3;
      status_p2 <= status_s3;
    end
  end

  assign out_valid = vld_p2;
  assign z         = z_p2;
  assign status    = status_p2;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe: real-arithmetic reference model, random and directed traffic.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, z;
  logic [2:0]  rm;
  logic [7:0]  status;

  always #5 clk = ~clk;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .round(rm), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .status(status)
  );

  typedef struct {
    logic [31:0] z;
    logic [7:0]  st;
    logic [31:0] a, b;
    logic [2:0]  rm;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   rand_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic real to_real(input logic [31:0] x);
    logic [63:0] d;
    d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Exact product in double precision, then IEEE-style rounding to single format.
  function automatic logic [39:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic [2:0] mode);
    int ex, ey, e, be, md;
    bit nx, ny, ix, iy, zx, zy, s, inc, to_inf;
    real p, mag, q, fl, rem;
    longint mi;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    nx = (ex == 255) && (x[22:0] != 0); ny = (ey == 255) && (y[22:0] != 0);
    ix = (ex == 255) && (x[22:0] == 0); iy = (ey == 255) && (y[22:0] == 0);
    zx = (ex == 0); zy = (ey == 0);
    s  = x[31] ^ y[31];
    md = (mode > 3'd5) ? 0 : int'(mode);
    if (nx || ny || (ix && zy) || (zx && iy)) return {8'h04, 32'h7FC00000};
    if (ix || iy) return {8'h02, s, 31'h7F800000};
    if (zx || zy) return {8'h01, s, 31'h0};
    p = to_real(x) * to_real(y);
    mag = (p < 0.0) ? -p : p;
    e = 0;
    while (mag >= 2.0) begin mag = mag / 2.0; e++; end
    while (mag < 1.0) begin mag = mag * 2.0; e--; end
    be = e + 127;
    if (be < 1) begin
      case (md)
        5: return {8'h28, s, 31'h00800000};
        2: return s ? {8'h29, 1'b1, 31'h0} : {8'h28, 1'b0, 31'h00800000};
        3: return s ? {8'h28, 1'b1, 31'h00800000} : {8'h29, 1'b0, 31'h0};
        default: return {8'h29, s, 31'h0};
      endcase
    end
    q   = mag * 8388608.0;
    fl  = $floor(q);
    rem = q - fl;
    mi  = longint'(fl);
    case (md)
      1: inc = 0;
      2: inc = !s && (rem > 0.0);
      3: inc = s && (rem > 0.0);
      4: inc = (rem > 0.5) || ((rem == 0.5) && !s);
      5: inc = (rem > 0.0);
      default: inc = (rem > 0.5) || ((rem == 0.5) && (mi % 2 == 1));
    endcase
    mi = mi + longint'(inc);
    if (mi == 64'd16777216) begin mi = 64'd8388608; be++; end
    if (be > 254) begin
      case (md)
        1: to_inf = 0;
        2: to_inf = !s;
        3: to_inf = s;
        default: to_inf = 1;
      endcase
      return to_inf ? {8'h32, s, 31'h7F800000} : {8'h30, s, 31'h7F7FFFFF};
    end
    return {((rem != 0.0) ? 8'h20 : 8'h00), s, 8'(be), 23'(mi - 64'd8388608)};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic        s;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom);
    case ($urandom_range(0, 11))
      0: case ($urandom_range(0, 3))
           0: return {s, 8'h00, 23'h0};
           1: return {s, 8'hFF, 23'h0};
           2: return {s, 8'hFF, m | 23'h1};
           default: return {s, 8'h00, m | 23'h1};
         endcase
      1: return $urandom;
      2: return {s, 8'($urandom_range(1, 40)), m};
      3: return {s, 8'($urandom_range(200, 254)), m};
      4: return {s, 8'd127, 23'($urandom_range(0, 3))};
      default: return {s, 8'($urandom_range(90, 165)), m};
    endcase
  endfunction

  // Called and returns at posedge+1; pushes the expectation on the accepting cycle.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] tr,
                      input bit use_c, input logic [31:0] cz, input logic [7:0] cst);
    exp_t        e;
    logic [39:0] m;
    int          n;
    a = ta; b = tb; rm = tr; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        break;
      end
      @(posedge clk); #1;
    end
    m = ref_mul(ta, tb, tr);
    e.z = use_c ? cz : m[31:0];
    e.st = use_c ? cst : m[39:32];
    e.a = ta; e.b = tb; e.rm = tr;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while (sb_q.size() != 0 && n < limit) begin @(posedge clk); #1; n++; end
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: compares every delivered result and checks hold behaviour under stall.
  initial begin : monitor
    bit          held = 0;
    logic [31:0] hz;
    logic [7:0]  hst;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_z", z, hz);
          chk("hold_status", 32'(status), 32'(hst));
        end
        if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (!out_valid) chk("empty_in_ready", 32'(in_ready), 32'd1);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: z=%h status=%h with nothing outstanding", z, status);
          end else begin
            e = sb_q.pop_front();
            chk($sformatf("z a=%h b=%h rm=%0d", e.a, e.b, e.rm), z, e.z);
            chk($sformatf("status a=%h b=%h rm=%0d", e.a, e.b, e.rm), 32'(status), 32'(e.st));
          end
        end
        held = out_valid && !out_ready;
        hz = z; hst = status;
      end
    end
  end

  initial begin : main
    int lat, seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; rm = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_z", z, 32'd0);
    chk("reset_status", 32'(status), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    mon_en = 1;

    // Latency on an idle pipeline
    send(32'h3FC00000, 32'h40000000, 3'd0, 1, 32'h40400000, 8'h00);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    @(posedge clk); #1;

    // Directed values with known answers
    send(32'h7F000000, 32'h7F000000, 3'd0, 1, 32'h7F800000, 8'h32);
    send(32'h7F000000, 32'h7F000000, 3'd1, 1, 32'h7F7FFFFF, 8'h30);
    send(32'h7F800000, 32'h00000000, 3'd0, 1, 32'h7FC00000, 8'h04);
    send(32'h00800000, 32'h00800000, 3'd0, 1, 32'h00000000, 8'h29);
    send(32'hFF000000, 32'h7F000000, 3'd3, 1, 32'hFF800000, 8'h32);
    send(32'hFF000000, 32'h7F000000, 3'd2, 1, 32'hFF7FFFFF, 8'h30);
    send(32'h00800000, 32'h00800000, 3'd5, 1, 32'h00800000, 8'h28);
    send(32'h80800000, 32'h00800000, 3'd2, 1, 32'h80000000, 8'h29);
    send(32'h80800000, 32'h00800000, 3'd3, 1, 32'h80800000, 8'h28);
    send(32'hFF800000, 32'h3F800000, 3'd0, 1, 32'hFF800000, 8'h02);
    send(32'h80000000, 32'h40000000, 3'd0, 1, 32'h80000000, 8'h01);
    send(32'h00000001, 32'h40000000, 3'd0, 1, 32'h00000000, 8'h01);
    send(32'h3FC00000, 32'h40000000, 3'd6, 1, 32'h40400000, 8'h00);
    send(32'h3FFFFFFE, 32'h3F800001, 3'd0, 1, 32'h40000000, 8'h20);
    send(32'h3FFFFFFE, 32'h3F800001, 3'd1, 1, 32'h3FFFFFFF, 8'h20);
    foreach (sb_q[i]) ;
    for (int k = 0; k < 6; k++) begin
      logic [2:0] md;
      md = (k < 4) ? 3'(k == 3 ? 5 : k) : 3'(k);
      send(32'h3F800001, 32'h3F800001, md, 0, '0, '0);
    end
    drain("drain_directed", 50);

    // Four back-to-back operations against a five-cycle output stall
    fork
      begin
        for (int k = 0; k < 4; k++)
          send({1'b0, 8'($urandom_range(100, 150)), 23'($urandom)},
               {1'b1, 8'($urandom_range(100, 150)), 23'($urandom)}, 3'($urandom_range(0, 5)), 0, '0, '0);
      end
      begin
        out_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_stall", 50);

    // Reset with two operations in flight
    send(32'h40000000, 32'h40400000, 3'd0, 0, '0, '0);
    send(32'h40800000, 32'h40400000, 3'd0, 0, '0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_z", z, 32'd0);
    chk("midreset_status", 32'(status), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midreset_no_ghost", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // Randomised traffic with random backpressure
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          if (!rand_done) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 500; i++) begin
      send(rnd_op(), rnd_op(), 3'($urandom_range(0, 7)), 0, '0, '0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rand_done = 1;
    idle(2);
    out_ready = 1'b1;
    drain("drain_random", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
